// File: rtl/fp_to_int_seq_if.sv
// Operand/result channel of fp_to_int_seq.
//
// Handshake: each direction uses valid/ready. A transfer happens on a
// rising clk edge where valid and ready are both 1. The producer holds its
// payload stable while valid=1 and ready=0. On the input side the block
// raises in_ready only when it is idle. On the output side it holds
// out_valid, intgr and ovf stable until the consumer raises out_ready.
interface fp_to_int_seq_if;
    logic [31:0] fp;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] intgr;
    logic        out_valid;
    logic        out_ready;
    logic        ovf;

    // Producer of operands and consumer of results.
    modport master (
        output fp, in_valid, out_ready,
        input  in_ready, intgr, out_valid, ovf
    );

    // The converter itself.
    modport slave (
        input  fp, in_valid, out_ready,
        output in_ready, intgr, out_valid, ovf
    );
endinterface

// File: rtl/fp_to_int_seq.sv
// Sequential IEEE-754 single-precision to signed 32-bit integer converter.
// The mantissa is moved one bit per cycle, and right shifts truncate toward
// zero. Only one operation is in flight at a time.
// Build option: define FP_TO_INT_SATURATE_EN to saturate out-of-range
// results (NaN gives 0). Without it, every invalid or overflow case gives
// 0x80000000. ovf is set in all of these cases.
module fp_to_int_seq (
    input  logic                  clk,
    input  logic                  rst,
    fp_to_int_seq_if.slave        bus,
    output logic [2:0]            dbg_state
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        SHIFT  = 3'd2,
        NEG    = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state;
    logic [31:0] fp_q;
    logic [31:0] acc;
    logic [4:0]  n;
    logic        shl;

    // Fields of the latched operand.
    logic        sgn;
    logic [7:0]  expo;
    logic [22:0] frac;
    logic        is_small;
    logic        is_ovf;
    logic [31:0] ovf_value;
    logic [4:0]  n_left;
    logic [4:0]  n_right;

    assign sgn  = fp_q[31];
    assign expo = fp_q[30:23];
    assign frac = fp_q[22:0];

    assign dbg_state = state;

    // A biased exponent of 150 means unbiased e=23. At that value the
    // mantissa already sits at the integer point.
    assign n_left  = 5'(expo - 8'd150);
    assign n_right = 5'(8'd150 - expo);

    // Classify the operand. Values below 1.0, including zero and
    // denormals, truncate to 0. For e=31, only -2^31 fits.
    always_comb begin
        is_small = (expo < 8'd127);
        is_ovf   = (expo == 8'd255) || (expo > 8'd158) ||
                   ((expo == 8'd158) && (fp_q != 32'hCF00_0000));
`ifdef FP_TO_INT_SATURATE_EN
        if ((expo == 8'd255) && (frac != 23'd0))
            ovf_value = 32'h0000_0000;
        else if (sgn)
            ovf_value = 32'h8000_0000;
        else
            ovf_value = 32'h7FFF_FFFF;
`else
        ovf_value = 32'h8000_0000;
`endif
    end

    // Control FSM and datapath. All outputs are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            fp_q          <= 32'd0;
            acc           <= 32'd0;
            n             <= 5'd0;
            shl           <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.intgr     <= 32'd0;
            bus.ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        fp_q         <= bus.fp;
                        bus.in_ready <= 1'b0;
                        state        <= DECODE;
                    end
                end
                DECODE: begin
                    if (is_small) begin
                        bus.intgr     <= 32'd0;
                        bus.ovf       <= 1'b0;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else if (is_ovf) begin
                        bus.intgr     <= ovf_value;
                        bus.ovf       <= 1'b1;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        acc <= {8'b0, 1'b1, frac};
                        if (expo > 8'd150) begin
                            shl   <= 1'b1;
                            n     <= n_left;
                            state <= SHIFT;
                        end else if (expo < 8'd150) begin
                            shl   <= 1'b0;
                            n     <= n_right;
                            state <= SHIFT;
                        end else begin
                            n     <= 5'd0;
                            state <= NEG;
                        end
                    end
                end
                SHIFT: begin
                    acc <= shl ? (acc << 1) : (acc >> 1);
                    n   <= n - 5'd1;
                    if (n == 5'd1)
                        state <= NEG;
                end
                NEG: begin
                    bus.intgr     <= sgn ? (~acc + 32'd1) : acc;
                    bus.ovf       <= 1'b0;
                    bus.out_valid <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.intgr     <= 32'd0;
                        bus.ovf       <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        acc           <= 32'd0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.in_ready  <= 1'b1;
                    bus.out_valid <= 1'b0;
                    bus.intgr     <= 32'd0;
                    bus.ovf       <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fp_to_int_seq.sv
// Directed testbench for fp_to_int_seq. Expected values are hand-computed.
// Results that depend on FP_TO_INT_SATURATE_EN follow the same macro.
module tb_fp_to_int_seq;
    logic       clk;
    logic       rst;
    logic [2:0] dbg_state;
    int         total;
    int         bad;

    fp_to_int_seq_if bus ();

    fp_to_int_seq dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

`ifdef FP_TO_INT_SATURATE_EN
    localparam logic [31:0] OVF_POS = 32'h7FFF_FFFF;
    localparam logic [31:0] NAN_VAL = 32'h0000_0000;
`else
    localparam logic [31:0] OVF_POS = 32'h8000_0000;
    localparam logic [31:0] NAN_VAL = 32'h8000_0000;
`endif

    // Normal operands: fp, expected integer, expected latency (2+n).
    localparam int NN = 9;
    localparam logic [31:0] NORM_FP  [NN] = '{32'h44B6_0000, 32'hBF80_0000, 32'h4020_0000,
                                              32'h3F80_0000, 32'hC4B6_0000, 32'h4B80_0000,
                                              32'h4B00_0000, 32'h4EFF_FFFF, 32'hC020_0000};
    localparam logic [31:0] NORM_RES [NN] = '{32'h0000_05B0, 32'hFFFF_FFFF, 32'h0000_0002,
                                              32'h0000_0001, 32'hFFFF_FA50, 32'h0100_0000,
                                              32'h0080_0000, 32'h7FFF_FF80, 32'hFFFF_FFFE};
    localparam int          NORM_LAT [NN] = '{15, 25, 24, 25, 15, 3, 2, 9, 24};

    // Boundary and special operands: fp, integer, ovf, latency.
    localparam int NB = 12;
    localparam logic [31:0] BND_FP  [NB] = '{32'hCF00_0000, 32'h4F00_0000, 32'h4F32_D05E,
                                             32'hCF00_0001, 32'h7F80_0000, 32'hFF80_0000,
                                             32'h7FC0_0000, 32'hFFC0_0000, 32'h0000_0001,
                                             32'h3F00_0000, 32'h3F7F_FFFF, 32'h8000_0000};
    localparam logic [31:0] BND_RES [NB] = '{32'h8000_0000, OVF_POS, OVF_POS,
                                             32'h8000_0000, OVF_POS, 32'h8000_0000,
                                             NAN_VAL, NAN_VAL, 32'h0000_0000,
                                             32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    localparam logic        BND_OVF [NB] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                                             1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam int          BND_LAT [NB] = '{10, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: present an operand, wait for the accept, then count edges
    // until out_valid. With finish=1, one more edge completes the result
    // handshake (out_ready is assumed high). A timeout returns lat >= 100.
    task automatic send_op(input logic [31:0] v, input bit finish,
                           output logic [31:0] res, output logic f, output int lat);
        int guard;
        guard = 0;
        bus.fp = v;
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            bus.in_valid = 1'b0;
            lat = 999;
            res = 'x;
            f = 1'bx;
        end else begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            lat = 0;
            do begin
                @(posedge clk); #1;
                lat++;
            end while (bus.out_valid !== 1'b1 && lat < 100);
            res = bus.intgr;
            f = bus.ovf;
            if (finish) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.fp = 32'd0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.intgr !== 32'd0) begin bad++; $display("FAIL reset_intgr got=%h want=00000000", bus.intgr); end
        total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
        total++; if (dbg_state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", dbg_state); end
        rst = 1'b0;
    endtask

    task automatic test_normal();
        logic [31:0] res;
        logic        f;
        int          lat;
        for (int i = 0; i < NN; i++) begin
            send_op(NORM_FP[i], 1'b1, res, f, lat);
            total++; if (res !== NORM_RES[i]) begin bad++; $display("FAIL normal_result fp=%h got=%h want=%h", NORM_FP[i], res, NORM_RES[i]); end
            total++; if (f !== 1'b0) begin bad++; $display("FAIL normal_ovf fp=%h got=%b want=0", NORM_FP[i], f); end
            total++; if (lat != NORM_LAT[i]) begin bad++; $display("FAIL normal_latency fp=%h got=%0d want=%0d", NORM_FP[i], lat, NORM_LAT[i]); end
            total++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin bad++; $display("FAIL normal_return_idle fp=%h got in_ready=%b out_valid=%b want 1/0", NORM_FP[i], bus.in_ready, bus.out_valid); end
        end
    endtask

    task automatic test_boundary();
        logic [31:0] res;
        logic        f;
        int          lat;
        for (int i = 0; i < NB; i++) begin
            send_op(BND_FP[i], 1'b1, res, f, lat);
            total++; if (res !== BND_RES[i]) begin bad++; $display("FAIL boundary_result fp=%h got=%h want=%h", BND_FP[i], res, BND_RES[i]); end
            total++; if (f !== BND_OVF[i]) begin bad++; $display("FAIL boundary_ovf fp=%h got=%b want=%b", BND_FP[i], f, BND_OVF[i]); end
            total++; if (lat != BND_LAT[i]) begin bad++; $display("FAIL boundary_latency fp=%h got=%0d want=%0d", BND_FP[i], lat, BND_LAT[i]); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] res;
        logic        f;
        int          lat;
        bus.out_ready = 1'b0;
        send_op(32'h44B6_0000, 1'b0, res, f, lat);
        total++; if (res !== 32'h0000_05B0 || lat != 15) begin bad++; $display("FAIL stall_first got=%h lat=%0d want=000005B0 lat=15", res, lat); end
        // A new operand offered while DONE is held must be ignored.
        bus.fp = 32'h3F80_0000;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid cyc=%0d got=%b want=1", c, bus.out_valid); end
            total++; if (bus.intgr !== 32'h0000_05B0) begin bad++; $display("FAIL stall_intgr cyc=%0d got=%h want=000005B0", c, bus.intgr); end
            total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready cyc=%0d got=%b want=0", c, bus.in_ready); end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_release got out_valid=%b in_ready=%b want 0/1", bus.out_valid, bus.in_ready); end
        total++; if (bus.intgr !== 32'd0 || dbg_state !== 3'd0) begin bad++; $display("FAIL stall_release_idle got intgr=%h state=%0d want 00000000/0", bus.intgr, dbg_state); end
        send_op(32'h4020_0000, 1'b1, res, f, lat);
        total++; if (res !== 32'h0000_0002 || lat != 24) begin bad++; $display("FAIL stall_after got=%h lat=%0d want=00000002 lat=24", res, lat); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic        f;
        int          lat;
        int          pulses;
        bus.out_ready = 1'b1;
        bus.fp = 32'h44B6_0000;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++; if (dbg_state !== 3'd2) begin bad++; $display("FAIL midreset_in_shift got=%0d want=2", dbg_state); end
        #2 rst = 1'b1;
        #1;
        total++; if (dbg_state !== 3'd0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL midreset_async got state=%0d in_ready=%b want 0/1", dbg_state, bus.in_ready); end
        total++; if (bus.out_valid !== 1'b0 || bus.intgr !== 32'd0 || bus.ovf !== 1'b0) begin bad++; $display("FAIL midreset_outputs got ov=%b intgr=%h ovf=%b want 0/00000000/0", bus.out_valid, bus.intgr, bus.ovf); end
        pulses = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) pulses++;
        end
        rst = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.out_valid === 1'b1) pulses++;
        end
        total++; if (pulses != 0) begin bad++; $display("FAIL midreset_no_result got=%0d pulses want=0", pulses); end
        // Accept right after release.
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        send_op(32'h3F80_0000, 1'b1, res, f, lat);
        total++; if (res !== 32'h0000_0001 || f !== 1'b0) begin bad++; $display("FAIL midreset_next got=%h ovf=%b want=00000001/0", res, f); end
        total++; if (lat != 25) begin bad++; $display("FAIL midreset_next_latency got=%0d want=25", lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic        f;
        int          lat;
        send_op(32'h7F80_0000, 1'b1, res, f, lat);
        total++; if (res !== OVF_POS || f !== 1'b1) begin bad++; $display("FAIL b2b_first got=%h ovf=%b want=%h/1", res, f, OVF_POS); end
        send_op(32'hC4B6_0000, 1'b1, res, f, lat);
        total++; if (res !== 32'hFFFF_FA50 || f !== 1'b0 || lat != 15) begin bad++; $display("FAIL b2b_second got=%h ovf=%b lat=%0d want=FFFFFA50/0/15", res, f, lat); end
        send_op(32'h0000_0001, 1'b1, res, f, lat);
        total++; if (res !== 32'd0 || f !== 1'b0 || lat != 1) begin bad++; $display("FAIL b2b_third got=%h ovf=%b lat=%0d want=00000000/0/1", res, f, lat); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_normal();
        test_boundary();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
